// File: rtl/srl_fifo_reader.sv
// srl_fifo_reader: pops narrow words from an srl_fifo and packs RATIO of them into one wide valid/ready word.
// Optional feature macro SRL_RD_FLUSH_EN adds flush/m_keep so a partially filled word can be emitted.
module srl_fifo_reader #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned RATIO = 4,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fifo_empty,
    input  logic [CNT_W:0]           fifo_item_no,
    output logic                     fifo_rd,
    input  logic [WIDTH-1:0]         fifo_q,
    output logic                     m_valid,
    output logic [WIDTH*RATIO-1:0]   m_data,
    input  logic                     m_ready
`ifdef SRL_RD_FLUSH_EN
    ,
    input  logic                     flush,
    output logic [RATIO-1:0]         m_keep
`endif
);

    localparam int unsigned LANE_W = $clog2(RATIO);
    localparam int unsigned FILL_W = $clog2(RATIO + 1);
    localparam int unsigned PEND_W = FILL_W + 1;

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t                      r_state;
    logic [RATIO-1:0][WIDTH-1:0] r_lanes;
    logic [LANE_W-1:0]           r_lane_idx;
    logic [FILL_W-1:0]           r_fill_cnt;
    logic                        r_rd_d1;
    logic                        r_m_valid;
    logic [WIDTH*RATIO-1:0]      r_m_data;

    logic [PEND_W-1:0]           w_pend;
    logic                        w_out_free;
    logic                        w_last;
    logic                        w_full_xfer;
    logic                        w_flush_xfer;
    logic                        w_xfer;
    logic                        w_pop_blk;
    logic                        w_rd;
    logic [FILL_W-1:0]           w_fill_nxt;
    logic [RATIO-1:0][WIDTH-1:0] w_word;
    logic [RATIO-1:0][WIDTH-1:0] w_out_word;
    logic                        w_unused_item_no;

    // Occupancy is informational only; the empty flag alone drives popping.
    assign w_unused_item_no = ^fifo_item_no;

    // pend = lanes already filled plus the (at most one) read still in flight.
    assign w_pend      = PEND_W'(r_fill_cnt) + PEND_W'(r_rd_d1);
    assign w_out_free  = !r_m_valid || m_ready;
    assign w_last      = r_rd_d1 && (r_fill_cnt == FILL_W'(RATIO - 1));
    assign w_full_xfer = w_out_free && (w_last || (r_state == ST_HOLD));
    assign w_xfer      = w_full_xfer || w_flush_xfer;
    assign w_rd        = !fifo_empty && !rst && !w_pop_blk &&
                         ((w_pend < PEND_W'(RATIO)) || w_xfer);
    assign w_fill_nxt  = w_xfer ? '0 : r_fill_cnt + FILL_W'(r_rd_d1);

    assign fifo_rd = w_rd;
    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;

    // Assembly word including the lane landing this cycle, so a completing word can bypass HOLD.
    always_comb begin
        w_word = r_lanes;
        if (r_rd_d1) begin
            w_word[r_lane_idx] = fifo_q;
        end
    end

`ifdef SRL_RD_FLUSH_EN
    logic                        r_flush_pend;
    logic [RATIO-1:0]            r_m_keep;
    logic [RATIO-1:0]            w_part_keep;
    logic [RATIO-1:0][WIDTH-1:0] w_part_word;
    logic                        w_flush_done;

    // Pops stop on the flush pulse itself and stay stopped until the partial word leaves.
    assign w_pop_blk    = flush || r_flush_pend;
    assign w_flush_xfer = r_flush_pend && !r_rd_d1 && (r_state == ST_FILL) &&
                          (r_fill_cnt != '0) && w_out_free;
    assign w_flush_done = r_flush_pend && !r_rd_d1 && (r_state == ST_FILL) &&
                          ((r_fill_cnt == '0) || w_out_free);
    assign w_out_word   = w_flush_xfer ? w_part_word : w_word;
    assign m_keep       = r_m_keep;

    always_comb begin
        w_part_keep = '0;
        w_part_word = '0;
        for (int unsigned k = 0; k < RATIO; k++) begin
            w_part_keep[k] = (FILL_W'(k) < r_fill_cnt);
            w_part_word[k] = w_part_keep[k] ? r_lanes[k] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flush_pend <= 1'b0;
            r_m_keep     <= '0;
        end else begin
            if (r_flush_pend) begin
                if (w_flush_done) begin
                    r_flush_pend <= 1'b0;
                end
            end else if (flush) begin
                r_flush_pend <= 1'b1;
            end
            if (w_flush_xfer) begin
                r_m_keep <= w_part_keep;
            end else if (w_full_xfer) begin
                r_m_keep <= '1;
            end
        end
    end
`else
    assign w_pop_blk    = 1'b0;
    assign w_flush_xfer = 1'b0;
    assign w_out_word   = w_word;
`endif

    // Lane assembly, FILL/HOLD state and the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_FILL;
            r_lanes    <= '0;
            r_lane_idx <= '0;
            r_fill_cnt <= '0;
            r_rd_d1    <= 1'b0;
            r_m_valid  <= 1'b0;
            r_m_data   <= '0;
        end else begin
            r_rd_d1    <= w_rd;
            r_fill_cnt <= w_fill_nxt;
            if (r_rd_d1) begin
                r_lanes[r_lane_idx] <= fifo_q;
                r_lane_idx <= (r_lane_idx == LANE_W'(RATIO - 1)) ? '0
                                                                  : r_lane_idx + LANE_W'(1);
            end
            if (w_flush_xfer) begin
                r_lane_idx <= '0;
            end
            case (r_state)
                ST_FILL: begin
                    if (w_last && !w_full_xfer) begin
                        r_state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (w_full_xfer) begin
                        r_state <= ST_FILL;
                    end
                end
                default: r_state <= ST_FILL;
            endcase
            if (w_xfer) begin
                r_m_valid <= 1'b1;
                r_m_data  <= w_out_word;
            end else if (m_ready) begin
                r_m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_srl_fifo_reader.sv
// tb_srl_fifo_reader: directed scoreboard bench for srl_fifo_reader with a behavioural srl_fifo model.
// Flush scenarios are built only when SRL_RD_FLUSH_EN is defined.
module tb_srl_fifo_reader;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned RATIO = 4;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned CNT_W = $clog2(DEPTH);
    localparam int unsigned DW    = WIDTH * RATIO;

    logic             clk = 1'b0;
    logic             rst;
    logic             fifo_empty;
    logic [CNT_W:0]   fifo_item_no;
    logic             fifo_rd;
    logic [WIDTH-1:0] fifo_q = '0;
    logic             m_valid;
    logic [DW-1:0]    m_data;
    logic             m_ready;
`ifdef SRL_RD_FLUSH_EN
    logic             flush;
    logic [RATIO-1:0] m_keep;
    logic [RATIO-1:0] exp_k[$];
`endif

    logic [DW-1:0]    exp_q[$];
    logic [WIDTH-1:0] mem [0:63];
    int               wp = 0;
    int               rp = 0;
    bit               rd_empty_seen = 1'b0;
    int               checks = 0;
    int               errors = 0;
    int               cyc = 0;
    int               first_rd;
    int               last_rd;
    int               first_valid;
    int               rd_cnt;
    int               start;

    always #5 clk = ~clk;

    srl_fifo_reader #(
        .WIDTH(WIDTH), .RATIO(RATIO), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .fifo_empty(fifo_empty),
        .fifo_item_no(fifo_item_no),
        .fifo_rd(fifo_rd),
        .fifo_q(fifo_q),
        .m_valid(m_valid),
        .m_data(m_data),
        .m_ready(m_ready)
`ifdef SRL_RD_FLUSH_EN
        ,
        .flush(flush),
        .m_keep(m_keep)
`endif
    );

    // FIFO model: one-cycle read latency, not rewound by the reader's reset.
    assign fifo_empty   = (wp == rp);
    assign fifo_item_no = (CNT_W + 1)'(wp - rp);

    always @(posedge clk) begin
        if (fifo_rd && fifo_empty) rd_empty_seen <= 1'b1;
        if (fifo_rd && !fifo_empty) begin
            fifo_q <= mem[rp[5:0]];
            rp     <= rp + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic load(input logic [WIDTH-1:0] w);
        mem[wp[5:0]] = w;
        wp = wp + 1;
    endtask

    task automatic expect_full(input logic [DW-1:0] d);
        exp_q.push_back(d);
`ifdef SRL_RD_FLUSH_EN
        exp_k.push_back('1);
`endif
    endtask

    // Sample at the falling edge, then advance to just after the next rising edge.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (fifo_rd) begin
            rd_cnt++;
            if (first_rd < 0) first_rd = cyc;
            last_rd = cyc;
        end
        if (m_valid && first_valid < 0) first_valid = cyc;
        if (m_valid && m_ready) begin
            chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                chk("m_data", 32'(m_data), 32'(exp_q.pop_front()));
`ifdef SRL_RD_FLUSH_EN
                chk("m_keep", 32'(m_keep), 32'(exp_k.pop_front()));
`endif
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic clr_stats();
        first_rd    = -1;
        last_rd     = -1;
        first_valid = -1;
        rd_cnt      = 0;
    endtask

    initial begin
        rst     = 1'b1;
        m_ready = 1'b0;
`ifdef SRL_RD_FLUSH_EN
        flush   = 1'b0;
`endif
        clr_stats();
        tick();
        tick();
        chk("reset_fifo_rd", 32'(fifo_rd), 32'd0);
        chk("reset_m_valid", 32'(m_valid), 32'd0);
        chk("reset_m_data", 32'(m_data), 32'd0);
`ifdef SRL_RD_FLUSH_EN
        chk("reset_m_keep", 32'(m_keep), 32'd0);
`endif
        rst = 1'b0;
        tick();

        // Streaming 1..8 with the sink always ready.
        m_ready = 1'b1;
        clr_stats();
        for (int i = 1; i <= 8; i++) load(WIDTH'(i));
        expect_full(16'h4321);
        expect_full(16'h8765);
        drain("stream_drain", 40);
        chk("stream_first_valid_lat", 32'(first_valid - first_rd), 32'd5);
        chk("stream_rd_count", 32'(rd_cnt), 32'd8);
        chk("stream_rd_span", 32'(last_rd - first_rd), 32'd7);
        tick();

        // Backpressure: only RATIO words beyond the held output word may be popped.
        m_ready = 1'b0;
        start = rp;
        for (int i = 1; i <= 12; i++) load(WIDTH'(i));
        expect_full(16'h4321);
        expect_full(16'h8765);
        expect_full(16'hCBA9);
        for (int i = 0; i < 12; i++) begin
            tick();
            if (m_valid) chk("bp_hold_data", 32'(m_data), 32'h4321);
        end
        chk("bp_valid_held", 32'(m_valid), 32'd1);
        chk("bp_pop_count", 32'(rp - start), 32'd8);
        chk("bp_rd_stalled", 32'(fifo_rd), 32'd0);
        m_ready = 1'b1;
        #1;
        chk("bp_rd_resume", 32'(fifo_rd), 32'd1);
        drain("bp_drain", 40);
        tick();

        // Underrun: FIFO runs dry after two words, lane order must continue.
        load(4'h1);
        load(4'h2);
        expect_full(16'h4321);
        for (int i = 0; i < 7; i++) tick();
        chk("underrun_no_valid", 32'(m_valid), 32'd0);
        load(4'h3);
        load(4'h4);
        drain("underrun_drain", 20);
        tick();

        // Reset after two pops: the partial word and the in-flight word are dropped.
        start = rp;
        load(4'h1);
        load(4'h2);
        for (int i = 0; i < 10 && (rp - start) < 2; i++) tick();
        chk("rst_mid_pops", 32'(rp - start), 32'd2);
        rst = 1'b1;
        for (int i = 5; i <= 8; i++) load(WIDTH'(i));
        #1;
        chk("rst_mid_rd_gated", 32'(fifo_rd), 32'd0);
        tick();
        chk("rst_mid_rd", 32'(fifo_rd), 32'd0);
        chk("rst_mid_valid", 32'(m_valid), 32'd0);
        chk("rst_mid_data", 32'(m_data), 32'd0);
        chk("rst_mid_no_pop", 32'(rp - start), 32'd2);
        rst = 1'b0;
        expect_full(16'h8765);
        drain("rst_mid_drain", 20);
        tick();

`ifdef SRL_RD_FLUSH_EN
        // Flush a two-lane partial word after a full one.
        for (int i = 1; i <= 6; i++) load(WIDTH'(i));
        exp_q.push_back(16'h4321);
        exp_k.push_back(4'hF);
        exp_q.push_back(16'h0065);
        exp_k.push_back(4'h3);
        for (int i = 0; i < 10; i++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drain("flush_drain", 20);
        tick();

        // Flush with nothing assembled emits nothing, then normal packing resumes.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("flush_empty_no_valid", 32'(m_valid), 32'd0);
        end
        for (int i = 1; i <= 4; i++) load(WIDTH'(i));
        expect_full(16'h4321);
        drain("flush_resume_drain", 20);
        tick();
`endif

        chk("rd_while_empty", 32'(rd_empty_seen), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
